// File: rtl/npcg_toggle_bnc_p_read_if.sv
// Purpose: bundles the dispatcher command port, the primitive-manager (PM)
//          port and the read-data stream of the BNC page-read sequencer.
// Ports:   slave  - sequencer view (takes commands, drives PM, forwards data)
//          master - environment view (dispatcher + PM + requester)
interface npcg_toggle_bnc_p_read_if #(
  parameter int NumberOfWays = 4
) ();
  // dispatcher command
  logic [5:0]              iOpcode;
  logic [4:0]              iTargetID;
  logic [4:0]              iSourceID;
  logic [15:0]             iLength;
  logic                    iCMDValid;
  logic                    oCMDReady;
  logic [NumberOfWays-1:0] iWaySelect;
  logic [15:0]             iColAddress;
  logic [23:0]             iRowAddress;
  logic                    oStart;
  logic                    oLastStep;
  // primitive manager
  logic [7:0]              iPM_Ready;
  logic [7:0]              iPM_LastStep;
  logic [7:0]              oPM_PCommand;
  logic [2:0]              oPM_PCommandOption;
  logic [NumberOfWays-1:0] oPM_TargetWay;
  logic [15:0]             oPM_NumOfData;
  logic                    oPM_CASelect;
  logic [7:0]              oPM_CAData;
  // read stream
  logic [31:0]             iPM_ReadData;
  logic                    iPM_ReadLast;
  logic                    iPM_ReadValid;
  logic                    oPM_ReadReady;
  logic [31:0]             oReadData;
  logic                    oReadLast;
  logic                    oReadValid;
  logic                    iReadReady;

  modport slave (
    input  iOpcode, iTargetID, iSourceID, iLength, iCMDValid, iWaySelect,
           iColAddress, iRowAddress, iPM_Ready, iPM_LastStep,
           iPM_ReadData, iPM_ReadLast, iPM_ReadValid, iReadReady,
    output oCMDReady, oStart, oLastStep, oPM_PCommand, oPM_PCommandOption,
           oPM_TargetWay, oPM_NumOfData, oPM_CASelect, oPM_CAData,
           oPM_ReadReady, oReadData, oReadLast, oReadValid
  );

  modport master (
    output iOpcode, iTargetID, iSourceID, iLength, iCMDValid, iWaySelect,
           iColAddress, iRowAddress, iPM_Ready, iPM_LastStep,
           iPM_ReadData, iPM_ReadLast, iPM_ReadValid, iReadReady,
    input  oCMDReady, oStart, oLastStep, oPM_PCommand, oPM_PCommandOption,
           oPM_TargetWay, oPM_NumOfData, oPM_CASelect, oPM_CAData,
           oPM_ReadReady, oReadData, oReadLast, oReadValid
  );
endinterface

// File: rtl/npcg_toggle_bnc_p_read.sv
// Purpose: NAND page-read sequencer. Takes one read command and drives the
//          primitive manager through page load (00h/addr/30h, tWB) and data
//          out (05h/col/E0h, tWHR, DDR data-in). Read data is a pure
//          combinational pass-through from PM to requester.
// Ports:   iSystemClock - clock, all state on rising edge
//          iReset_n     - asynchronous active-low reset
//          bus          - command, PM and read-stream signals (slave view)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for a command
// S_CAL0     | CAL trigger for page-load bytes, wait PM ready
// S_PSEL     | page-select prefix command byte (A2h or 0xh)
// S_CMD00    | 00h
// S_A0..S_A4 | col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]
// S_CMD30    | 30h, or 32h for multi-plane
// S_TWB      | tWB timer trigger, wait CAL done
// S_CAL1     | CAL trigger for data-out bytes
// S_CMD05    | 05h
// S_C0, S_C1 | col[7:0], col[15:8]
// S_CMDE0    | E0h
// S_TWHR     | tWHR timer trigger, wait CAL done
// S_DI       | DDR data-in trigger, wait timer done
// S_DONE_TMR | wait timer done, then completion pulse
// S_DONE_DI  | wait data-in done, then completion pulse
module npcg_toggle_bnc_p_read #(
  parameter int NumberOfWays = 4
) (
  input logic                   iSystemClock,
  input logic                   iReset_n,
  npcg_toggle_bnc_p_read_if.slave bus
);

  typedef enum logic [4:0] {
    S_IDLE, S_CAL0, S_PSEL, S_CMD00, S_A0, S_A1, S_A2, S_A3, S_A4, S_CMD30,
    S_TWB, S_CAL1, S_CMD05, S_C0, S_C1, S_CMDE0, S_TWHR, S_DI,
    S_DONE_TMR, S_DONE_DI
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q;     // [1] skip page load, [0] skip data out
  logic [3:0]              src_q;    // {multi-plane, page-sel[1:0], page-option}
  logic [NumberOfWays-1:0] way_q;
  logic [15:0]             col_q;
  logic [23:0]             row_q;
  logic [15:0]             len_q;

  logic trigger, accept, psel, pm_all_ready;

  assign trigger = bus.iCMDValid && (bus.iTargetID == 5'b00101) &&
                   (bus.iOpcode[5:3] == 3'b010) && (bus.iOpcode[1:0] != 2'b11);
  assign accept       = (state_q == S_IDLE) && trigger;
  assign psel         = (src_q[2:1] != 2'b00) || src_q[0];
  assign pm_all_ready = (bus.iPM_Ready[6:0] == 7'h7F);

  logic unused_bits;
  assign unused_bits = ^{bus.iOpcode[2], bus.iSourceID[4], bus.iPM_Ready[7],
                         bus.iPM_LastStep[7:4]};

  always_ff @(posedge iSystemClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      way_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.iOpcode[1:0];
        src_q <= bus.iSourceID[3:0];
        way_q <= bus.iWaySelect;
        col_q <= bus.iColAddress;
        row_q <= bus.iRowAddress;
        len_q <= bus.iLength;
      end
    end
  end

  always_comb begin
    state_d                = state_q;
    bus.oPM_PCommand       = 8'h00;
    bus.oPM_PCommandOption = 3'b000;
    bus.oPM_NumOfData      = 16'd0;
    bus.oPM_CASelect       = 1'b0;
    bus.oPM_CAData         = 8'h00;
    bus.oLastStep          = 1'b0;
    unique case (state_q)
      S_IDLE: if (trigger) state_d = bus.iOpcode[1] ? S_CAL1 : S_CAL0;
      S_CAL0: begin
        bus.oPM_PCommand  = 8'h08;
        bus.oPM_NumOfData = psel ? 16'd6 : 16'd5;
        if (pm_all_ready) state_d = psel ? S_PSEL : S_CMD00;
      end
      S_PSEL: begin
        bus.oPM_CAData = (src_q[2:1] == 2'b00) ? 8'hA2 : {6'b0, src_q[2:1]};
        state_d        = S_CMD00;
      end
      S_CMD00: state_d = S_A0;
      S_A0: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = col_q[7:0];   state_d = S_A1; end
      S_A1: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = col_q[15:8];  state_d = S_A2; end
      S_A2: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = row_q[7:0];   state_d = S_A3; end
      S_A3: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = row_q[15:8];  state_d = S_A4; end
      S_A4: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = row_q[23:16]; state_d = S_CMD30; end
      S_CMD30: begin
        bus.oPM_CAData = src_q[3] ? 8'h32 : 8'h30;
        state_d        = S_TWB;
      end
      // Timer is launched while the CAL primitive drains; leave on CAL done.
      S_TWB: begin
        bus.oPM_PCommand       = 8'h01;
        bus.oPM_PCommandOption = 3'b110;
        bus.oPM_NumOfData      = 16'd10;
        if (bus.iPM_LastStep[3]) state_d = op_q[0] ? S_DONE_TMR : S_CAL1;
      end
      // After a page load the tWB timer must expire; otherwise PM must be idle.
      S_CAL1: begin
        bus.oPM_PCommand  = 8'h08;
        bus.oPM_NumOfData = 16'd3;
        if (op_q[1] ? pm_all_ready : bus.iPM_LastStep[0]) state_d = S_CMD05;
      end
      S_CMD05: begin bus.oPM_CAData = 8'h05; state_d = S_C0; end
      S_C0: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = col_q[7:0];  state_d = S_C1; end
      S_C1: begin bus.oPM_CASelect = 1'b1; bus.oPM_CAData = col_q[15:8]; state_d = S_CMDE0; end
      S_CMDE0: begin bus.oPM_CAData = 8'hE0; state_d = S_TWHR; end
      S_TWHR: begin
        bus.oPM_PCommand       = 8'h01;
        bus.oPM_PCommandOption = 3'b111;
        bus.oPM_NumOfData      = 16'd11;
        if (bus.iPM_LastStep[3]) state_d = S_DI;
      end
      S_DI: begin
        bus.oPM_PCommand       = 8'h02;
        bus.oPM_PCommandOption = 3'b001;
        bus.oPM_NumOfData      = len_q;
        if (bus.iPM_LastStep[0]) state_d = S_DONE_DI;
      end
      S_DONE_TMR: if (bus.iPM_LastStep[0]) begin
        bus.oLastStep = 1'b1;
        state_d       = S_IDLE;
      end
      S_DONE_DI: if (bus.iPM_LastStep[1]) begin
        bus.oLastStep = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.oCMDReady     = (state_q == S_IDLE);
  assign bus.oStart        = trigger;
  assign bus.oPM_TargetWay = way_q;

  assign bus.oPM_ReadReady = bus.iReadReady;
  assign bus.oReadData     = bus.iPM_ReadData;
  assign bus.oReadLast     = bus.iPM_ReadLast;
  assign bus.oReadValid    = bus.iPM_ReadValid;

endmodule

// File: tb/tb_npcg_toggle_bnc_p_read.sv
module tb_npcg_toggle_bnc_p_read;

  localparam logic [1:0] K_TRIG = 2'd0, K_CA = 2'd1, K_DATA = 2'd2, K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  pc;
    logic [2:0]  opt;
    logic [3:0]  way;
    logic        cs;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npcg_toggle_bnc_p_read_if #(.NumberOfWays(4)) bus ();
  npcg_toggle_bnc_p_read #(.NumberOfWays(4)) dut (
    .iSystemClock(clk),
    .iReset_n    (rst_n),
    .bus         (bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic mon_cmp(input string nm, input ev_t a);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: actual event %h required none", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", nm, a, e);
      end
    end
  endtask

  task automatic exp_trig(input logic [7:0] pc, input logic [2:0] opt,
                          input logic [3:0] way, input logic [15:0] len);
    ev_t e;
    e = '0; e.kind = K_TRIG; e.pc = pc; e.opt = opt; e.way = way; e.d = {16'h0, len};
    exp_q.push_back(e);
  endtask

  task automatic exp_ca(input logic cs, input logic [7:0] b);
    ev_t e;
    e = '0; e.kind = K_CA; e.cs = cs; e.d = {24'h0, b};
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e = '0; e.kind = K_DONE;
    exp_q.push_back(e);
  endtask

  // Monitor: turns DUT activity into events and checks them against the queue.
  initial begin : monitor
    logic [7:0] prev_pc;
    logic       in_ca;
    ev_t        a;
    prev_pc = '0;
    in_ca   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pc = '0;
        in_ca   = 1'b0;
      end else begin
        if (bus.oPM_PCommand != 8'h00 && bus.oPM_PCommand != prev_pc) begin
          a = '0; a.kind = K_TRIG; a.pc = bus.oPM_PCommand; a.opt = bus.oPM_PCommandOption;
          a.way = bus.oPM_TargetWay; a.d = {16'h0, bus.oPM_NumOfData};
          mon_cmp("trigger", a);
          in_ca = (bus.oPM_PCommand == 8'h08);
        end else if (bus.oPM_PCommand == 8'h00 && in_ca && !bus.oCMDReady) begin
          a = '0; a.kind = K_CA; a.cs = bus.oPM_CASelect; a.d = {24'h0, bus.oPM_CAData};
          mon_cmp("ca_byte", a);
        end
        if (bus.oCMDReady) in_ca = 1'b0;
        if (bus.oReadValid) begin
          a = '0; a.kind = K_DATA; a.cs = bus.oReadLast; a.d = bus.oReadData;
          mon_cmp("read_data", a);
          chk("read_ready", {63'h0, bus.oPM_ReadReady}, {63'h0, bus.iReadReady});
        end
        if (bus.oLastStep) begin
          a = '0; a.kind = K_DONE;
          mon_cmp("last_step", a);
        end
        prev_pc = bus.oPM_PCommand;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [5:0] op, input logic [4:0] src, input logic [3:0] way,
                       input logic [15:0] col, input logic [23:0] row, input logic [15:0] len);
    @(posedge clk); #1;
    bus.iOpcode = op; bus.iTargetID = 5'b00101; bus.iSourceID = src; bus.iWaySelect = way;
    bus.iColAddress = col; bus.iRowAddress = row; bus.iLength = len; bus.iCMDValid = 1'b1;
    @(negedge clk);
    chk("start_on_valid", {63'h0, bus.oStart}, 64'h1);
    chk("cmd_ready_idle", {63'h0, bus.oCMDReady}, 64'h1);
    @(posedge clk); #1;
    // scramble command inputs so only latched values can be used
    bus.iCMDValid = 1'b0; bus.iOpcode = 6'h00; bus.iSourceID = 5'h1F; bus.iWaySelect = 4'h0;
    bus.iColAddress = 16'hFFFF; bus.iRowAddress = 24'h0; bus.iLength = 16'hFFFF;
  endtask

  task automatic wait_pcmd(input logic [7:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.oPM_PCommand == pc) seen = 1'b1;
    end
    chk("wait_pcommand", {63'h0, seen}, 64'h1);
  endtask

  task automatic pulse_ls(input int idx);
    @(posedge clk); #1;
    bus.iPM_LastStep = 8'h01 << idx;
    @(posedge clk); #1;
    bus.iPM_LastStep = 8'h00;
  endtask

  // wait for a trigger, verify it is held, then report the awaited completion
  task automatic pm_trig(input logic [7:0] pc, input int idx, input int hold);
    wait_pcmd(pc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("pcommand_held", {56'h0, bus.oPM_PCommand}, {56'h0, pc});
    end
    pulse_ls(idx);
  endtask

  task automatic drive_words(input int n, input logic [31:0] base);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.iPM_ReadData = base + i; bus.iPM_ReadLast = (i == n - 1);
      bus.iPM_ReadValid = 1'b1; bus.iReadReady = 1'b1;
      e = '0; e.kind = K_DATA; e.cs = (i == n - 1); e.d = base + i;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.iPM_ReadValid = 1'b0; bus.iPM_ReadLast = 1'b0; bus.iPM_ReadData = '0;
  endtask

  task automatic wait_idle(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.oCMDReady) seen = 1'b1;
    end
    chk({nm, "_idle"}, {63'h0, seen}, 64'h1);
    @(negedge clk);
    chk({nm, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {bus.oCMDReady, bus.oLastStep, bus.oPM_PCommand, bus.oPM_PCommandOption,
             bus.oPM_TargetWay, bus.oPM_NumOfData, bus.oPM_CASelect, bus.oPM_CAData},
        {1'b1, 1'b0, 8'h00, 3'b000, 4'h0, 16'h0000, 1'b0, 8'h00});
  endtask

  initial begin : stim
    bus.iOpcode = '0; bus.iTargetID = '0; bus.iSourceID = '0; bus.iLength = '0;
    bus.iCMDValid = 1'b0; bus.iWaySelect = '0; bus.iColAddress = '0; bus.iRowAddress = '0;
    bus.iPM_Ready = 8'hFF; bus.iPM_LastStep = 8'h00; bus.iPM_ReadData = '0;
    bus.iPM_ReadLast = 1'b0; bus.iPM_ReadValid = 1'b0; bus.iReadReady = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: full read, no page select
    exp_trig(8'h08, 3'b000, 4'b0010, 16'd5);
    exp_ca(0, 8'h00); exp_ca(1, 8'h34); exp_ca(1, 8'h12);
    exp_ca(1, 8'hEF); exp_ca(1, 8'hCD); exp_ca(1, 8'hAB); exp_ca(0, 8'h30);
    exp_trig(8'h01, 3'b110, 4'b0010, 16'd10);
    exp_trig(8'h08, 3'b000, 4'b0010, 16'd3);
    exp_ca(0, 8'h05); exp_ca(1, 8'h34); exp_ca(1, 8'h12); exp_ca(0, 8'hE0);
    exp_trig(8'h01, 3'b111, 4'b0010, 16'd11);
    exp_trig(8'h02, 3'b001, 4'b0010, 16'd3);
    issue(6'b010000, 5'b00000, 4'b0010, 16'h1234, 24'hABCDEF, 16'd3);
    pm_trig(8'h01, 3, 2);
    pm_trig(8'h08, 0, 3);
    pm_trig(8'h01, 3, 1);
    pm_trig(8'h02, 0, 2);
    drive_words(4, 32'hD000_0010);
    exp_done();
    pulse_ls(1);
    wait_idle("t1");

    // 2: skip data out, page option only -> A2h prefix, timer completion
    exp_trig(8'h08, 3'b000, 4'b0100, 16'd6);
    exp_ca(0, 8'hA2); exp_ca(0, 8'h00); exp_ca(1, 8'h78); exp_ca(1, 8'h56);
    exp_ca(1, 8'h56); exp_ca(1, 8'h34); exp_ca(1, 8'h12); exp_ca(0, 8'h30);
    exp_trig(8'h01, 3'b110, 4'b0100, 16'd10);
    issue(6'b010001, 5'b00001, 4'b0100, 16'h5678, 24'h123456, 16'd9);
    pm_trig(8'h01, 3, 2);
    pulse_ls(1);
    @(negedge clk);
    chk("t2_ignores_di_done", {63'h0, bus.oCMDReady}, 64'h0);
    exp_done();
    pulse_ls(0);
    wait_idle("t2");

    // 3: skip page load; CAL1 gated by PM ready, not by timer done
    bus.iPM_Ready = 8'h00;
    exp_trig(8'h08, 3'b000, 4'b1000, 16'd3);
    exp_ca(0, 8'h05); exp_ca(1, 8'h40); exp_ca(1, 8'h00); exp_ca(0, 8'hE0);
    exp_trig(8'h01, 3'b111, 4'b1000, 16'd11);
    exp_trig(8'h02, 3'b001, 4'b1000, 16'd1);
    issue(6'b010010, 5'b00000, 4'b1000, 16'h0040, 24'h000001, 16'd1);
    pm_trig(8'h08, 0, 3);
    @(negedge clk);
    chk("t3_cal1_gated", {56'h0, bus.oPM_PCommand}, 64'h08);
    @(posedge clk); #1;
    bus.iPM_Ready = 8'h7F;
    pm_trig(8'h01, 3, 1);
    pm_trig(8'h02, 0, 1);
    drive_words(2, 32'hC0DE_0000);
    exp_done();
    pulse_ls(1);
    wait_idle("t3");
    bus.iPM_Ready = 8'hFF;

    // 4: multi-plane with page select 2
    exp_trig(8'h08, 3'b000, 4'b0001, 16'd6);
    exp_ca(0, 8'h02); exp_ca(0, 8'h00); exp_ca(1, 8'h01); exp_ca(1, 8'h00);
    exp_ca(1, 8'h03); exp_ca(1, 8'h02); exp_ca(1, 8'h00); exp_ca(0, 8'h32);
    exp_trig(8'h01, 3'b110, 4'b0001, 16'd10);
    issue(6'b010001, 5'b01100, 4'b0001, 16'h0001, 24'h000203, 16'd0);
    pm_trig(8'h01, 3, 1);
    exp_done();
    pulse_ls(0);
    wait_idle("t4");

    // 5: opcode[1:0]=11 and wrong target are never accepted
    @(posedge clk); #1;
    bus.iOpcode = 6'b010011; bus.iTargetID = 5'b00101; bus.iCMDValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_start_op11", {63'h0, bus.oStart}, 64'h0);
      chk("t5_ready_op11", {63'h0, bus.oCMDReady}, 64'h1);
    end
    @(posedge clk); #1;
    bus.iOpcode = 6'b010000; bus.iTargetID = 5'b00100;
    @(negedge clk);
    chk("t5_no_start_target", {63'h0, bus.oStart}, 64'h0);
    @(posedge clk); #1;
    bus.iCMDValid = 1'b0;
    wait_idle("t5");

    // 6: reset during DI with requester ready toggling, then a normal command
    exp_trig(8'h08, 3'b000, 4'b0010, 16'd5);
    exp_ca(0, 8'h00); exp_ca(1, 8'h02); exp_ca(1, 8'h01);
    exp_ca(1, 8'h05); exp_ca(1, 8'h04); exp_ca(1, 8'h03); exp_ca(0, 8'h30);
    exp_trig(8'h01, 3'b110, 4'b0010, 16'd10);
    exp_trig(8'h08, 3'b000, 4'b0010, 16'd3);
    exp_ca(0, 8'h05); exp_ca(1, 8'h02); exp_ca(1, 8'h01); exp_ca(0, 8'hE0);
    exp_trig(8'h01, 3'b111, 4'b0010, 16'd11);
    exp_trig(8'h02, 3'b001, 4'b0010, 16'd7);
    issue(6'b010000, 5'b00000, 4'b0010, 16'h0102, 24'h030405, 16'd7);
    pm_trig(8'h01, 3, 0);
    pm_trig(8'h08, 0, 0);
    pm_trig(8'h01, 3, 0);
    wait_pcmd(8'h02);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.iReadReady = ~bus.iReadReady;
      @(negedge clk);
      chk("t6_read_ready_toggle", {63'h0, bus.oPM_ReadReady}, {63'h0, bus.iReadReady});
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async_reset");
    chk("t6_queue_after_reset", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_trig(8'h08, 3'b000, 4'b0001, 16'd3);
    exp_ca(0, 8'h05); exp_ca(1, 8'h11); exp_ca(1, 8'h22); exp_ca(0, 8'hE0);
    exp_trig(8'h01, 3'b111, 4'b0001, 16'd11);
    exp_trig(8'h02, 3'b001, 4'b0001, 16'd0);
    issue(6'b010010, 5'b00000, 4'b0001, 16'h2211, 24'h332211, 16'd0);
    pm_trig(8'h01, 3, 0);
    pm_trig(8'h02, 0, 0);
    drive_words(1, 32'hBEEF_0000);
    exp_done();
    pulse_ls(1);
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
